// File: rtl/vga_timing_pkg.sv
// Shared constants, payload struct and helpers for the parametrised VGA timing generator.
package vga_timing_pkg;

    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_WHITE = 2'd3;

    // Stage-0 control and coordinates carried together down the alignment pipe
    typedef struct packed {
        logic           fs;
        logic           vis;
        logic           hs;
        logic           vs;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pipe_t;

    // Sum of the four segments of a line or a frame
    function automatic int unsigned seg_total(input int unsigned act, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // Colour-bar channel mask {B,G,R}: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [2:0] bar_bgr(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b011;
            3'd2:    return 3'b110;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b001;
            3'd6:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen_param_delay_line.sv
// Fixed-depth shift register; depth 0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift one stage per clock
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VAL;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator with frame-buffer addressing and test patterns.
module vga_timing_gen_param
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic                   iVGA_CLK,
    input  logic                   iRST,
    input  logic                   iEN,
    input  logic [1:0]             iMODE,
    input  logic [3*COLOR_W-1:0]   iPIX_BGR,
    output logic [ADDR_W-1:0]      oADDR,
    output logic                   oADDR_VALID,
    output logic [X_W-1:0]         oX,
    output logic [Y_W-1:0]         oY,
    output logic                   oHS,
    output logic                   oVS,
    output logic                   oBLANK_n,
    output logic [COLOR_W-1:0]     oVGA_R,
    output logic [COLOR_W-1:0]     oVGA_G,
    output logic [COLOR_W-1:0]     oVGA_B,
    output logic                   oFRAME_START
);

    localparam int unsigned H_TOTAL  = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned PIX_LAST = H_ACTIVE * V_ACTIVE - 1;
    localparam int unsigned PIPE_W   = $bits(pipe_t);
    localparam longint unsigned ADDR_CAP = 64'd1 << ADDR_W;
    localparam longint unsigned PIX_CNT  = 64'(H_ACTIVE) * 64'(V_ACTIVE);
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    // Reject parameter sets the counters or address bus cannot represent
    generate
        if (H_TOTAL > 2048) begin : g_bad_h_total
            $error("H_TOTAL exceeds 2048");
        end
        if (V_TOTAL > 1024) begin : g_bad_v_total
            $error("V_TOTAL exceeds 1024");
        end
        if (PIPE_LAT > 7) begin : g_bad_pipe_lat
            $error("PIPE_LAT exceeds 7");
        end
        if (ADDR_CAP < PIX_CNT) begin : g_bad_addr_w
            $error("ADDR_W too narrow for H_ACTIVE*V_ACTIVE");
        end
    endgenerate

    logic [X_W-1:0]    h_cnt;
    logic [Y_W-1:0]    v_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        mode_q;
    logic              h_last_c;
    logic              v_last_c;
    logic              vis_c;
    logic              hs_c;
    logic              vs_c;
    logic              fs_c;
    pipe_t             s0_c;
    pipe_t             dl;

    // Stage-0 decode; everything is forced inactive while disabled
    always_comb begin
        h_last_c = (32'(h_cnt) == H_TOTAL - 1);
        v_last_c = (32'(v_cnt) == V_TOTAL - 1);
        vis_c    = iEN && (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
        hs_c     = iEN && (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
        vs_c     = iEN && (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
        fs_c     = iEN && (h_cnt == '0) && (v_cnt == '0);
        s0_c     = '{fs: fs_c, vis: vis_c, hs: hs_c, vs: vs_c, x: h_cnt, y: v_cnt};
    end

    // Raster counters and linear address; address holds at the last pixel until frame wrap
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else if (!iEN) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else begin
            if (h_last_c) begin
                h_cnt <= '0;
                v_cnt <= v_last_c ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
            if (h_last_c && v_last_c) begin
                addr_cnt <= '0;
            end else if (vis_c && (addr_cnt != ADDR_W'(PIX_LAST))) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
        end
    end

    // Pattern mode only changes at the top-left of a frame
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            mode_q <= MODE_PASS;
        end else if ((h_cnt == '0) && (v_cnt == '0)) begin
            mode_q <= iMODE;
        end
    end

    assign oADDR       = addr_cnt;
    assign oADDR_VALID = vis_c & ~iRST;

    vga_delay_line #(
        .WIDTH     (PIPE_W),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL ('0)
    ) u_delay (
        .clk (iVGA_CLK),
        .rst (iRST),
        .d   (s0_c),
        .q   (dl)
    );

    logic [2:0]         bar_idx_c;
    logic [2:0]         mask_c;
    logic [COLOR_W-1:0] r_c;
    logic [COLOR_W-1:0] g_c;
    logic [COLOR_W-1:0] b_c;

    // Pixel colour from the delayed coordinates, black outside the visible area
    always_comb begin
        r_c       = '0;
        g_c       = '0;
        b_c       = '0;
        mask_c    = 3'b000;
        bar_idx_c = 3'((32'(dl.x) * 32'd8) / H_ACTIVE);
        if (dl.vis) begin
            case (mode_q)
                MODE_PASS: begin
                    r_c = iPIX_BGR[COLOR_W-1:0];
                    g_c = iPIX_BGR[2*COLOR_W-1:COLOR_W];
                    b_c = iPIX_BGR[3*COLOR_W-1:2*COLOR_W];
                end
                MODE_BARS:  mask_c = bar_bgr(bar_idx_c);
                MODE_CHECK: mask_c = (dl.x[5] ^ dl.y[5]) ? 3'b000 : 3'b111;
                default:    mask_c = 3'b111;
            endcase
            if (mode_q != MODE_PASS) begin
                r_c = {COLOR_W{mask_c[0]}};
                g_c = {COLOR_W{mask_c[1]}};
                b_c = {COLOR_W{mask_c[2]}};
            end
        end
    end

    // Output register: every DAC-side signal leaves from here
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            oHS          <= ~HS_ON;
            oVS          <= ~VS_ON;
            oBLANK_n     <= 1'b0;
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oX           <= '0;
            oY           <= '0;
            oFRAME_START <= 1'b0;
        end else begin
            oHS          <= dl.hs ? HS_ON : ~HS_ON;
            oVS          <= dl.vs ? VS_ON : ~VS_ON;
            oBLANK_n     <= dl.vis;
            oVGA_R       <= r_c;
            oVGA_G       <= g_c;
            oVGA_B       <= b_c;
            oX           <= dl.x;
            oY           <= dl.y;
            oFRAME_START <= dl.fs;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Directed bench: full-width/short-frame instance A and tiny instance B.
module tb_vga_timing_gen_param;

    localparam int A_HT = 800;
    localparam int A_FR = 16000;
    localparam int A_PL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 640/16/96/48 x 16/1/2/1, PIPE_LAT 2
    logic        rst_a, en_a;
    logic [1:0]  mode_a;
    logic [11:0] pix_a;
    logic [18:0] addr_a;
    logic        av_a, hs_a, vs_a, blank_a, fs_a;
    logic [10:0] x_a;
    logic [9:0]  y_a;
    logic [3:0]  r_a, g_a, b_a;

    // Instance B: 8/1/2/1 x 4/1/1/1, HS active-high, PIPE_LAT 1
    logic        rst_b, en_b;
    logic [1:0]  mode_b;
    logic [5:0]  pix_b;
    logic [4:0]  addr_b;
    logic        av_b, hs_b, vs_b, blank_b, fs_b;
    logic [10:0] x_b;
    logic [9:0]  y_b;
    logic [1:0]  r_b, g_b, b_b;

    // Two-cycle model RAM returning data = address
    logic [18:0] ram1 = '0;
    logic [18:0] ram2 = '0;
    always @(posedge clk) begin
        ram1 <= addr_a;
        ram2 <= ram1;
    end
    assign pix_a = ram2[11:0];
    assign pix_b = '0;

    vga_timing_gen_param #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(16), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .COLOR_W(4), .ADDR_W(19), .PIPE_LAT(A_PL)
    ) dut_a (
        .iVGA_CLK(clk), .iRST(rst_a), .iEN(en_a), .iMODE(mode_a), .iPIX_BGR(pix_a),
        .oADDR(addr_a), .oADDR_VALID(av_a), .oX(x_a), .oY(y_a), .oHS(hs_a), .oVS(vs_a),
        .oBLANK_n(blank_a), .oVGA_R(r_a), .oVGA_G(g_a), .oVGA_B(b_a), .oFRAME_START(fs_a)
    );

    vga_timing_gen_param #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .COLOR_W(2), .ADDR_W(5), .PIPE_LAT(1)
    ) dut_b (
        .iVGA_CLK(clk), .iRST(rst_b), .iEN(en_b), .iMODE(mode_b), .iPIX_BGR(pix_b),
        .oADDR(addr_b), .oADDR_VALID(av_b), .oX(x_b), .oY(y_b), .oHS(hs_b), .oVS(vs_b),
        .oBLANK_n(blank_b), .oVGA_R(r_b), .oVGA_G(g_b), .oVGA_B(b_b), .oFRAME_START(fs_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Observation cycle (edges since reset release) at which output pixel (x,y) of frame f appears in A
    function automatic int pc(input int x, input int y, input int f);
        return f * A_FR + y * A_HT + x + A_PL + 1;
    endfunction

    int cyc;
    int hs_low, vs_low, blank_hi, fs_cnt, hs_hi_b, blank_hi_b;
    int hf0, hf1, vf0, vf1, nhf, nvf;
    logic prev_hs, prev_vs;

    initial begin
        rst_a = 1'b1; en_a = 1'b1; mode_a = 2'd1;
        rst_b = 1'b1; en_b = 1'b1; mode_b = 2'd3;
        hs_low = 0; vs_low = 0; blank_hi = 0; fs_cnt = 0; hs_hi_b = 0; blank_hi_b = 0;
        hf0 = 0; hf1 = 0; vf0 = 0; vf1 = 0; nhf = 0; nvf = 0;
        repeat (3) @(negedge clk);

        check("a_rst_hs", 32'(hs_a), 1);
        check("a_rst_vs", 32'(vs_a), 1);
        check("a_rst_blank", 32'(blank_a), 0);
        check("a_rst_fs", 32'(fs_a), 0);
        check("a_rst_addr_valid", 32'(av_a), 0);
        check("b_rst_hs", 32'(hs_b), 0);

        rst_a = 1'b0;
        cyc = 0;
        #1;
        check("a_addr_first", 32'(addr_a), 0);
        check("a_addr_valid_first", 32'(av_a), 1);
        prev_hs = 1'b1;
        prev_vs = 1'b1;

        while (cyc < 40300) begin
            tick();
            cyc++;
            if (cyc >= 3 && cyc <= A_FR + 2) begin
                hs_low   += int'(!hs_a);
                vs_low   += int'(!vs_a);
                blank_hi += int'(blank_a);
                fs_cnt   += int'(fs_a);
            end
            if (prev_hs && !hs_a) begin
                if (nhf == 0) hf0 = cyc; else if (nhf == 1) hf1 = cyc;
                nhf++;
            end
            if (prev_vs && !vs_a) begin
                if (nvf == 0) vf0 = cyc; else if (nvf == 1) vf1 = cyc;
                nvf++;
            end
            prev_hs = hs_a;
            prev_vs = vs_a;

            if (cyc == 2) check("a_fs_early", 32'(fs_a), 0);
            if (cyc == pc(0, 0, 0)) check("a_fs_first", 32'(fs_a), 1);
            if (cyc == 4) check("a_fs_single", 32'(fs_a), 0);
            if (cyc == 800) check("a_addr_line1", 32'(addr_a), 640);
            if (cyc == pc(79, 0, 0)) check("a_bar_x79", {r_a, g_a, b_a}, 12'hFFF);
            if (cyc == pc(80, 0, 0)) check("a_bar_x80", {r_a, g_a, b_a}, 12'hFF0);
            if (cyc == pc(160, 0, 0)) check("a_bar_x160", {r_a, g_a, b_a}, 12'h0FF);
            if (cyc == pc(639, 0, 0)) begin
                check("a_bar_x639", {r_a, g_a, b_a}, 12'h000);
                check("a_blank_x639", 32'(blank_a), 1);
            end
            if (cyc == pc(640, 0, 0)) check("a_blank_x640", 32'(blank_a), 0);
            if (cyc == pc(640, 3, 0)) check("a_rgb_hblank", {r_a, g_a, b_a}, 12'h000);
            if (cyc == pc(300, 5, 0)) begin
                check("a_x_300", 32'(x_a), 300);
                check("a_y_5", 32'(y_a), 5);
            end
            if (cyc == pc(0, 8, 0)) mode_a = 2'd2;
            if (cyc == pc(80, 12, 0)) check("a_bar_persist", {r_a, g_a, b_a}, 12'hFF0);
            if (cyc == 12639) begin
                check("a_addr_last", 32'(addr_a), 10239);
                check("a_addr_valid_last", 32'(av_a), 1);
            end
            if (cyc == 12640) begin
                check("a_addr_hold", 32'(addr_a), 10239);
                check("a_addr_valid_off", 32'(av_a), 0);
            end
            if (cyc == A_FR) begin
                check("a_addr_wrap", 32'(addr_a), 0);
                check("a_addr_valid_wrap", 32'(av_a), 1);
            end
            if (cyc == pc(0, 0, 1)) begin
                check("a_fs_frame1", 32'(fs_a), 1);
                check("a_chk_00", {r_a, g_a, b_a}, 12'hFFF);
            end
            if (cyc == pc(32, 0, 1)) check("a_chk_x32", {r_a, g_a, b_a}, 12'h000);
            if (cyc == pc(64, 0, 1)) check("a_chk_x64", {r_a, g_a, b_a}, 12'hFFF);
            if (cyc == pc(0, 8, 1)) mode_a = 2'd0;
            if (cyc == pc(5, 0, 2)) check("a_pass_x5", {r_a, g_a, b_a}, 12'h500);
            if (cyc == pc(300, 1, 2)) check("a_pass_940", {r_a, g_a, b_a}, 12'hCA3);
        end

        check("a_hs_low_cycles", 32'(hs_low), 1920);
        check("a_vs_low_cycles", 32'(vs_low), 1600);
        check("a_blank_hi_cycles", 32'(blank_hi), 10240);
        check("a_fs_count", 32'(fs_cnt), 1);
        check("a_hs_fall0", 32'(hf0), 659);
        check("a_hs_period", 32'(hf1 - hf0), 800);
        check("a_vs_fall0", 32'(vf0), 13603);
        check("a_vs_period", 32'(vf1 - vf0), A_FR);

        // Mid-line reset at h=300, v=10
        check("a_pre_rst_blank", 32'(blank_a), 1);
        rst_a = 1'b1;
        mode_a = 2'd3;
        #1;
        check("a_arst_hs", 32'(hs_a), 1);
        check("a_arst_vs", 32'(vs_a), 1);
        check("a_arst_blank", 32'(blank_a), 0);
        check("a_arst_rgb", {r_a, g_a, b_a}, 12'h000);
        check("a_arst_x", 32'(x_a), 0);
        check("a_arst_y", 32'(y_a), 0);
        check("a_arst_fs", 32'(fs_a), 0);
        check("a_arst_addr", 32'(addr_a), 0);
        check("a_arst_addr_valid", 32'(av_a), 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cyc++;
            if (cyc == 2) check("a_rel_fs_early", 32'(fs_a), 0);
            if (cyc == 3) begin
                check("a_rel_fs", 32'(fs_a), 1);
                check("a_rel_white", {r_a, g_a, b_a}, 12'hFFF);
                check("a_rel_x", 32'(x_a), 0);
            end
            if (cyc == 4) check("a_rel_fs_single", 32'(fs_a), 0);
        end

        // Instance B
        rst_b = 1'b0;
        cyc = 0;
        #1;
        check("b_addr_first", 32'(addr_b), 0);
        check("b_addr_valid_first", 32'(av_b), 1);
        while (cyc < 100) begin
            tick();
            cyc++;
            if (cyc >= 2 && cyc <= 13) begin
                hs_hi_b    += int'(hs_b);
                blank_hi_b += int'(blank_b);
            end
            if (cyc == 2) begin
                check("b_fs_first", 32'(fs_b), 1);
                check("b_white", {r_b, g_b, b_b}, 6'h3F);
            end
            if (cyc == 10) check("b_hs_pre", 32'(hs_b), 0);
            if (cyc == 11) check("b_hs_start", 32'(hs_b), 1);
            if (cyc == 43) begin
                check("b_addr_last", 32'(addr_b), 31);
                check("b_addr_valid_last", 32'(av_b), 1);
            end
            if (cyc == 44) begin
                check("b_addr_hold", 32'(addr_b), 31);
                check("b_addr_valid_off", 32'(av_b), 0);
            end
            if (cyc == 84) check("b_addr_wrap", 32'(addr_b), 0);
            if (cyc == 90) begin
                en_b = 1'b0;
                #1;
                check("b_en_off_valid", 32'(av_b), 0);
            end
            if (cyc == 91) check("b_en_off_blank_lag", 32'(blank_b), 1);
            if (cyc == 92) begin
                check("b_en_off_blank", 32'(blank_b), 0);
                check("b_en_off_hs", 32'(hs_b), 0);
                check("b_en_off_rgb", {r_b, g_b, b_b}, 6'h00);
            end
            if (cyc == 93) check("b_en_off_x", 32'(x_b), 0);
            if (cyc == 94) check("b_en_off_fs", 32'(fs_b), 0);
            if (cyc == 95) begin
                en_b = 1'b1;
                #1;
                check("b_en_on_addr", 32'(addr_b), 0);
                check("b_en_on_valid", 32'(av_b), 1);
            end
            if (cyc == 96) begin
                check("b_resume_fs_early", 32'(fs_b), 0);
                check("b_resume_addr", 32'(addr_b), 1);
            end
            if (cyc == 97) begin
                check("b_resume_fs", 32'(fs_b), 1);
                check("b_resume_x", 32'(x_b), 0);
                check("b_resume_y", 32'(y_b), 0);
                check("b_resume_blank", 32'(blank_b), 1);
            end
            if (cyc == 98) check("b_resume_x1", 32'(x_b), 1);
        end
        check("b_hs_high_per_line", 32'(hs_hi_b), 2);
        check("b_blank_hi_per_line", 32'(blank_hi_b), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
